// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM ramp sequencer.
//   ramp_state_t     : sequencer FSM state encoding (idle / ramping)
//   interval_or_one  : maps a requested update interval of 0 onto 1 clock
package pwm_pkg;

  typedef enum logic [0:0] {
    RAMP_IDLE = 1'b0,
    RAMP_RUN  = 1'b1
  } ramp_state_t;

  // An interval of zero clocks is meaningless, so it is treated as one clock.
  function automatic int unsigned interval_or_one(input int unsigned interval);
    return (interval == 32'd0) ? 32'd1 : interval;
  endfunction

endpackage

// File: rtl/pwm_ramp_tick.sv
// Reloadable down-counter that paces ramp updates.
//   clk, rst : clock and synchronous active-high reset
//   clear    : zero the counter (sequencer leaving the ramp)
//   load     : capture period as both current count and reload value
//   run      : count while high
//   period   : reload value, i.e. interval - 1
//   tick     : high for the single cycle in which the count is 0 while running
module pwm_ramp_tick #(
  parameter int RATE_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  load,
  input  logic                  run,
  input  logic [RATE_WIDTH-1:0] period,
  output logic                  tick
);

  logic [RATE_WIDTH-1:0] count_q;
  logic [RATE_WIDTH-1:0] reload_q;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q  <= '0;
      reload_q <= '0;
    end else if (load) begin
      count_q  <= period;
      reload_q <= period;
    end else if (run) begin
      if (count_q == '0) count_q <= reload_q;
      else               count_q <= count_q - RATE_WIDTH'(1);
    end
  end

  assign tick = run && (count_q == '0);

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Command-driven duty-cycle ramp sequencer in front of a pwm instance.
// Accepts {target, step, interval} over valid/ready, then walks pwm_compare
// toward target by step every interval clocks without overshoot, pulsing done
// on arrival. A ramp that ends at zero duty also drops pwm_en.
//   clk, rst      : clock and synchronous active-high reset
//   cmd_valid     : command present
//   cmd_ready     : sequencer idle, command will be accepted
//   cmd_target    : final compare value
//   cmd_step      : compare change per update (0 = jump straight to target)
//   cmd_interval  : clocks between updates (0 treated as 1)
//   abort         : stop a running ramp in place
//   pwm_en        : drives pwm.en
//   pwm_compare   : drives pwm.compare
//   busy          : ramp in progress
//   done          : one-cycle pulse, target reached
module pwm_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int RATE_WIDTH = 16   // at most 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] cmd_target,
  input  logic [DATA_WIDTH-1:0] cmd_step,
  input  logic [RATE_WIDTH-1:0] cmd_interval,
  input  logic                  abort,
  output logic                  pwm_en,
  output logic [DATA_WIDTH-1:0] pwm_compare,
  output logic                  busy,
  output logic                  done
);

  ramp_state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] target_q;
  logic [DATA_WIDTH-1:0] step_q;
  logic [DATA_WIDTH-1:0] compare_q;
  logic                  en_q;
  logic                  done_q;

  // Command decode, only meaningful while idle.
  logic                  accept;
  logic                  cmd_equal;
  logic                  cmd_jump;
  logic                  ramp_start;
  logic [RATE_WIDTH-1:0] reload_value;

  assign accept       = cmd_valid && (state_q == RAMP_IDLE);
  assign cmd_equal    = (cmd_target == compare_q);
  assign cmd_jump     = !cmd_equal && (cmd_step == '0);
  assign ramp_start   = accept && !cmd_equal && (cmd_step != '0);
  assign reload_value = RATE_WIDTH'(interval_or_one(32'(cmd_interval)) - 32'd1);

  // Step arithmetic: the difference is one bit wider and signed so its sign
  // picks the direction; if the remaining distance fits in one step the
  // compare snaps to target, which rules out overshoot and wrap.
  logic signed [DATA_WIDTH:0]   diff;
  logic        [DATA_WIDTH:0]   mag;
  logic                         arrive;
  logic        [DATA_WIDTH-1:0] stepped;
  logic        [DATA_WIDTH-1:0] next_compare;

  assign diff         = $signed({1'b0, target_q}) - $signed({1'b0, compare_q});
  assign mag          = diff[DATA_WIDTH] ? $unsigned(-diff) : $unsigned(diff);
  assign arrive       = (mag <= {1'b0, step_q});
  assign stepped      = diff[DATA_WIDTH] ? (compare_q - step_q) : (compare_q + step_q);
  assign next_compare = arrive ? target_q : stepped;

  // Update pacing.
  logic tick;
  logic tick_clear;

  pwm_ramp_tick #(
    .RATE_WIDTH (RATE_WIDTH)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clear  (tick_clear),
    .load   (ramp_start),
    .run    (state_q == RAMP_RUN),
    .period (reload_value),
    .tick   (tick)
  );

  // Any exit from RUN (arrival or abort) leaves the counter at zero.
  assign tick_clear = (state_q == RAMP_RUN) && (state_d == RAMP_IDLE);

  // FSM: state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= RAMP_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state. Abort wins over a same-edge arrival.
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RAMP_IDLE: if (ramp_start)              state_d = RAMP_RUN;
      RAMP_RUN:  if (abort)                   state_d = RAMP_IDLE;
                 else if (tick && arrive)     state_d = RAMP_IDLE;
      default:                                state_d = RAMP_IDLE;
    endcase
  end

  // FSM: outputs, decoded from the state register only.
  always_comb begin
    cmd_ready = (state_q == RAMP_IDLE);
    busy      = (state_q == RAMP_RUN);
  end

  // Datapath: latched command, compare, enable and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      target_q  <= '0;
      step_q    <= '0;
      compare_q <= '0;
      en_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        target_q <= cmd_target;
        step_q   <= cmd_step;
        if ((cmd_target != '0) || (compare_q != '0)) en_q <= 1'b1;
        if (cmd_jump) compare_q <= cmd_target;
        if (cmd_equal || cmd_jump) done_q <= 1'b1;
      end else if ((state_q == RAMP_RUN) && !abort && tick) begin
        compare_q <= next_compare;
        if (arrive) begin
          done_q <= 1'b1;
          // Ending at zero duty parks the pwm with its counters in reset.
          if (target_q == '0) en_q <= 1'b0;
        end
      end
    end
  end

  assign pwm_en      = en_q;
  assign pwm_compare = compare_q;
  assign done        = done_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed testbench for pwm_ramp_ctrl. Status is observed as one packed
// vector {cmd_ready, busy, done, pwm_en, pwm_compare} one time unit after
// each rising edge; inputs are driven at the same point.
module tb_pwm_ramp_ctrl;

  localparam int DW = 8;
  localparam int RW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [DW-1:0] cmd_target;
  logic [DW-1:0] cmd_step;
  logic [RW-1:0] cmd_interval;
  logic          abort;
  logic          pwm_en;
  logic [DW-1:0] pwm_compare;
  logic          busy;
  logic          done;

  logic [11:0]   obs;
  logic [11:0]   exp_st;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pwm_ramp_ctrl #(
    .DATA_WIDTH (DW),
    .RATE_WIDTH (RW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_target   (cmd_target),
    .cmd_step     (cmd_step),
    .cmd_interval (cmd_interval),
    .abort        (abort),
    .pwm_en       (pwm_en),
    .pwm_compare  (pwm_compare),
    .busy         (busy),
    .done         (done)
  );

  assign obs = {cmd_ready, busy, done, pwm_en, pwm_compare};

  // Expected status word: ready, busy, done, en, compare.
  function automatic logic [11:0] st(input bit r, input bit b, input bit d,
                                     input bit e, input int c);
    return {r, b, d, e, 8'(c)};
  endfunction

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int target, input int stp, input int interval);
    cmd_valid    = 1'b1;
    cmd_target   = 8'(target);
    cmd_step     = 8'(stp);
    cmd_interval = 16'(interval);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step_clk();
    step_clk();
    exp_st = st(1, 0, 0, 0, 0);
    checks++;
    if (obs !== exp_st) begin
      errors++;
      $display("FAIL reset: got %h want %h", obs, exp_st);
    end
    rst = 1'b0;
  endtask

  // target 10, step 3, interval 4: 3,6,9,10 at edges 4,8,12,16.
  task automatic test_up_ramp();
    int up_cmp [16] = '{0, 0, 0, 3, 3, 3, 3, 6, 6, 6, 6, 9, 9, 9, 9, 10};
    send(10, 3, 4);
    step_clk();
    cmd_valid = 1'b0;
    exp_st = st(0, 1, 0, 1, 0);
    checks++;
    if (obs !== exp_st) begin
      errors++;
      $display("FAIL up_ramp accept: got %h want %h", obs, exp_st);
    end
    for (int e = 1; e <= 16; e++) begin
      step_clk();
      if (e < 16) exp_st = st(0, 1, 0, 1, up_cmp[e-1]);
      else        exp_st = st(1, 0, 1, 1, up_cmp[e-1]);
      checks++;
      if (obs !== exp_st) begin
        errors++;
        $display("FAIL up_ramp edge %0d: got %h want %h", e, obs, exp_st);
      end
    end
  endtask

  // Issued while done is still high from the up-ramp.
  task automatic test_back_to_back_down();
    logic [11:0] dn [3];
    dn[0] = st(0, 1, 0, 1, 6);
    dn[1] = st(0, 1, 0, 1, 2);
    dn[2] = st(1, 0, 1, 0, 0);
    send(0, 4, 1);
    step_clk();
    cmd_valid = 1'b0;
    exp_st = st(0, 1, 0, 1, 10);
    checks++;
    if (obs !== exp_st) begin
      errors++;
      $display("FAIL down accept on done: got %h want %h", obs, exp_st);
    end
    for (int e = 0; e < 3; e++) begin
      step_clk();
      checks++;
      if (obs !== dn[e]) begin
        errors++;
        $display("FAIL down edge %0d: got %h want %h", e + 1, obs, dn[e]);
      end
    end
    step_clk();
    exp_st = st(1, 0, 0, 0, 0);
    checks++;
    if (obs !== exp_st) begin
      errors++;
      $display("FAIL down done once: got %h want %h", obs, exp_st);
    end
  endtask

  task automatic test_immediate();
    send(200, 0, 5);
    step_clk();
    cmd_valid = 1'b0;
    exp_st = st(1, 0, 1, 1, 200);
    checks++;
    if (obs !== exp_st) begin
      errors++;
      $display("FAIL jump: got %h want %h", obs, exp_st);
    end
    step_clk();
    exp_st = st(1, 0, 0, 1, 200);
    checks++;
    if (obs !== exp_st) begin
      errors++;
      $display("FAIL jump done clear: got %h want %h", obs, exp_st);
    end
    send(200, 5, 1);
    step_clk();
    cmd_valid = 1'b0;
    exp_st = st(1, 0, 1, 1, 200);
    checks++;
    if (obs !== exp_st) begin
      errors++;
      $display("FAIL equal target: got %h want %h", obs, exp_st);
    end
  endtask

  // target 100, step 1, interval 2: updates 1,2 at edges 2,4; abort at edge 6.
  task automatic test_abort();
    int ab_cmp [5] = '{0, 1, 1, 2, 2};
    send(0, 0, 1);
    step_clk();
    cmd_valid = 1'b0;
    exp_st = st(1, 0, 1, 1, 0);
    checks++;
    if (obs !== exp_st) begin
      errors++;
      $display("FAIL abort setup: got %h want %h", obs, exp_st);
    end
    send(100, 1, 2);
    step_clk();
    cmd_valid = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      step_clk();
      exp_st = st(0, 1, 0, 1, ab_cmp[e-1]);
      checks++;
      if (obs !== exp_st) begin
        errors++;
        $display("FAIL abort ramp edge %0d: got %h want %h", e, obs, exp_st);
      end
    end
    abort = 1'b1;
    step_clk();
    abort = 1'b0;
    exp_st = st(1, 0, 0, 1, 2);
    checks++;
    if (obs !== exp_st) begin
      errors++;
      $display("FAIL abort hold: got %h want %h", obs, exp_st);
    end
    step_clk();
    checks++;
    if (obs !== exp_st) begin
      errors++;
      $display("FAIL abort no done: got %h want %h", obs, exp_st);
    end
  endtask

  task automatic test_edge_values();
    int n;
    bit found;
    // interval 0 acts as 1: from 2 to 5 in steps of 1 on consecutive edges.
    send(5, 1, 0);
    step_clk();
    cmd_valid = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      step_clk();
      if (e < 3) exp_st = st(0, 1, 0, 1, 2 + e);
      else       exp_st = st(1, 0, 1, 1, 5);
      checks++;
      if (obs !== exp_st) begin
        errors++;
        $display("FAIL interval0 edge %0d: got %h want %h", e, obs, exp_st);
      end
    end
    // 100 -> 255 with step 200 clamps to 255.
    send(100, 0, 1);
    step_clk();
    send(255, 200, 1);
    step_clk();
    cmd_valid = 1'b0;
    exp_st = st(0, 1, 0, 1, 100);
    checks++;
    if (obs !== exp_st) begin
      errors++;
      $display("FAIL clamp accept: got %h want %h", obs, exp_st);
    end
    step_clk();
    exp_st = st(1, 0, 1, 1, 255);
    checks++;
    if (obs !== exp_st) begin
      errors++;
      $display("FAIL clamp result: got %h want %h", obs, exp_st);
    end
    // cmd_valid held high with a different command while busy is ignored.
    send(250, 1, 3);
    step_clk();
    send(0, 0, 1);
    step_clk();
    step_clk();
    exp_st = st(0, 1, 0, 1, 255);
    checks++;
    if (obs !== exp_st) begin
      errors++;
      $display("FAIL held valid: got %h want %h", obs, exp_st);
    end
    cmd_valid = 1'b0;
    n = 2;
    found = 1'b0;
    while (!found && n < 40) begin
      step_clk();
      n++;
      if (done === 1'b1) found = 1'b1;
    end
    checks++;
    if (n != 15) begin
      errors++;
      $display("FAIL held valid arrival edge: got %0d want 15", n);
    end
    exp_st = st(1, 0, 1, 1, 250);
    checks++;
    if (obs !== exp_st) begin
      errors++;
      $display("FAIL held valid result: got %h want %h", obs, exp_st);
    end
  endtask

  task automatic test_reset_mid_ramp();
    send(0, 0, 1);
    step_clk();
    send(100, 10, 1);
    step_clk();
    cmd_valid = 1'b0;
    repeat (5) step_clk();
    exp_st = st(0, 1, 0, 1, 50);
    checks++;
    if (obs !== exp_st) begin
      errors++;
      $display("FAIL mid ramp at 50: got %h want %h", obs, exp_st);
    end
    rst = 1'b1;
    step_clk();
    rst = 1'b0;
    exp_st = st(1, 0, 0, 0, 0);
    checks++;
    if (obs !== exp_st) begin
      errors++;
      $display("FAIL mid ramp reset: got %h want %h", obs, exp_st);
    end
    send(7, 0, 1);
    step_clk();
    cmd_valid = 1'b0;
    exp_st = st(1, 0, 1, 1, 7);
    checks++;
    if (obs !== exp_st) begin
      errors++;
      $display("FAIL after reset cmd: got %h want %h", obs, exp_st);
    end
  endtask

  initial begin
    rst          = 1'b1;
    cmd_valid    = 1'b0;
    cmd_target   = '0;
    cmd_step     = '0;
    cmd_interval = '0;
    abort        = 1'b0;
    test_reset();
    test_up_ramp();
    test_back_to_back_down();
    test_immediate();
    test_abort();
    test_edge_values();
    test_reset_mid_ramp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
